// File: rtl/imager_pkg.sv
// imager_pkg: geometry constants and sequencer state encoding shared by the
// subframe sequencer and the pattern generator.
package imager_pkg;
    localparam int C_NUM_ROWS      = 160;
    localparam int C_WORDS_PER_ROW = 18;
    localparam int C_WORD_W        = 10;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_EXPOSE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;
    typedef enum logic [1:0] {
        IDLE   = S_IDLE,
        LOAD   = S_LOAD,
        EXPOSE = S_EXPOSE,
        DONE   = S_DONE
    } state_t;
endpackage

// File: rtl/subc_sequencer_if.sv
// subc_sequencer_if: pattern FIFO read side plus imager row-driver bus.
//   FIFO_empty/FIFO_dout : FIFO -> sequencer
//   FIFO_rd              : sequencer -> FIFO
//   Pat_data/Pat_valid/Row_sel/Row_load/Exp_en : sequencer -> imager
//   master = sequencer side, slave = FIFO/imager side
interface subc_sequencer_if import imager_pkg::*; #(
    parameter int C_WORD_W = imager_pkg::C_WORD_W
);
    logic                FIFO_empty;
    logic [C_WORD_W-1:0] FIFO_dout;
    logic                FIFO_rd;
    logic [C_WORD_W-1:0] Pat_data;
    logic                Pat_valid;
    logic [7:0]          Row_sel;
    logic                Row_load;
    logic                Exp_en;
    modport master (
        input  FIFO_empty, FIFO_dout,
        output FIFO_rd, Pat_data, Pat_valid, Row_sel, Row_load, Exp_en
    );
    modport slave (
        output FIFO_empty, FIFO_dout,
        input  FIFO_rd, Pat_data, Pat_valid, Row_sel, Row_load, Exp_en
    );
endinterface

// File: rtl/subc_row_counter.sv
// subc_row_counter: word/row position of the pattern word currently valid.
//   clk, rst : clock, async active-high reset
//   clr      : return to row 0, word 0
//   adv      : a word is valid this cycle; position advances after it
//   row      : row index of the current word
//   row_load : current word is the last of its row
//   last     : current word is the last of the subframe
module subc_row_counter import imager_pkg::*; #(
    parameter int C_NUM_ROWS      = imager_pkg::C_NUM_ROWS,
    parameter int C_WORDS_PER_ROW = imager_pkg::C_WORDS_PER_ROW
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       adv,
    output logic [7:0] row,
    output logic       row_load,
    output logic       last
);
    localparam int WW = $clog2(C_WORDS_PER_ROW);
    logic [WW-1:0] word;
    logic          end_row;
    assign end_row  = word == WW'(C_WORDS_PER_ROW - 1);
    assign row_load = adv & end_row;
    assign last     = row_load & (row == 8'(C_NUM_ROWS - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            word <= '0;
            row  <= '0;
        end else if (adv) begin
            word <= end_row ? '0 : word + 1'b1;
            row  <= last ? '0 : end_row ? row + 1'b1 : row;
        end
    end
endmodule

// File: rtl/subc_sequencer.sv
// subc_sequencer: reads one frame of pattern words from the FIFO as
// Num_Pat+2 subframes (LOAD then EXPOSE each) and tracks the subframe index.
//   clk, rst          : clock, async active-high reset
//   start             : frame start pulse, accepted in IDLE only
//   Num_Pat           : exposed subframes per frame (latched at start)
//   Exp_cycles        : EXPOSE length in cycles, 0 treated as 1 (latched)
//   bus               : FIFO read side and imager pattern/exposure outputs
//   CntSubc           : current exposed subframe index
//   busy              : high in LOAD and EXPOSE
//   frame_done        : one-cycle end-of-frame pulse
//   Stall_cnt         : LOAD cycles lost to an empty FIFO, saturating
module subc_sequencer import imager_pkg::*; #(
    parameter int C_NUM_ROWS      = imager_pkg::C_NUM_ROWS,
    parameter int C_WORDS_PER_ROW = imager_pkg::C_WORDS_PER_ROW
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [31:0]            Num_Pat,
    input  logic [31:0]            Exp_cycles,
    subc_sequencer_if.master       bus,
    output logic [31:0]            CntSubc,
    output logic                   busy,
    output logic                   frame_done,
    output logic [31:0]            Stall_cnt
);
    localparam int TOTAL = C_NUM_ROWS * C_WORDS_PER_ROW;
    localparam int IW    = $clog2(TOTAL + 1);
    state_t        state, state_n;
    logic [31:0]   np, ec, exp_cnt;
    logic [32:0]   sf;
    logic [IW-1:0] issued;
    logic          pending, last, exp_end;
    assign pending      = issued < IW'(TOTAL);
    assign bus.Pat_data = bus.Pat_valid ? bus.FIFO_dout : '0;
    subc_row_counter #(
        .C_NUM_ROWS(C_NUM_ROWS),
        .C_WORDS_PER_ROW(C_WORDS_PER_ROW)
    ) u_row (
        .clk(clk),
        .rst(rst),
        .clr(state == IDLE),
        .adv(bus.Pat_valid),
        .row(bus.Row_sel),
        .row_load(bus.Row_load),
        .last(last)
    );
    always_comb begin
        state_n     = state;
        bus.FIFO_rd = 1'b0;
        bus.Exp_en  = 1'b0;
        busy        = 1'b0;
        frame_done  = 1'b0;
        exp_end     = 1'b0;
        case (state)
            IDLE: state_n = start ? LOAD : IDLE;
            LOAD: begin
                busy        = 1'b1;
                bus.FIFO_rd = ~bus.FIFO_empty & pending;
                state_n     = last ? EXPOSE : LOAD;
            end
            EXPOSE: begin
                busy       = 1'b1;
                bus.Exp_en = (sf != '0) & (sf <= {1'b0, np});
                // 33-bit compare makes Exp_cycles = 0 behave as 1
                exp_end    = {1'b0, exp_cnt} + 33'd1 >= {1'b0, ec};
                state_n    = !exp_end ? EXPOSE : (sf < {1'b0, np} + 33'd1) ? LOAD : DONE;
            end
            default: begin
                frame_done = 1'b1;
                state_n    = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.Pat_valid <= 1'b0;
            np            <= '0;
            ec            <= '0;
            exp_cnt       <= '0;
            sf            <= '0;
            issued        <= '0;
            CntSubc       <= '0;
            Stall_cnt     <= '0;
        end else begin
            bus.Pat_valid <= bus.FIFO_rd;
            exp_cnt       <= state == EXPOSE ? exp_cnt + 1'b1 : '0;
            if (bus.FIFO_rd)
                issued <= issued + 1'b1;
            if (state == LOAD && bus.FIFO_empty && pending && ~&Stall_cnt)
                Stall_cnt <= Stall_cnt + 1'b1;
            if (state == IDLE && start) begin
                np        <= Num_Pat;
                ec        <= Exp_cycles;
                sf        <= '0;
                issued    <= '0;
                CntSubc   <= '0;
                Stall_cnt <= '0;
            end
            if (state == EXPOSE && state_n == LOAD) begin
                sf     <= sf + 33'd1;
                issued <= '0;
                if (sf + 33'd1 <= {1'b0, np})
                    CntSubc <= CntSubc + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_subc_sequencer.sv
// tb_subc_sequencer: directed frames against subc_sequencer with a counting
// FIFO model and a negedge monitor collecting per-frame statistics.
module tb_subc_sequencer;
    import imager_pkg::*;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, clr = 1'b0;
    logic [31:0] Num_Pat = '0, Exp_cycles = '0;
    logic [31:0] CntSubc, Stall_cnt;
    logic        busy, frame_done;
    subc_sequencer_if bus();
    subc_sequencer dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .Num_Pat(Num_Pat),
        .Exp_cycles(Exp_cycles),
        .bus(bus),
        .CntSubc(CntSubc),
        .busy(busy),
        .frame_done(frame_done),
        .Stall_cnt(Stall_cnt)
    );
    always #5 clk = ~clk;
    int n_tests = 0, n_fail = 0;
    int cyc = 0, seq = 0, t0 = 0;
    int rd_n, rd_empty_n, rl_n, rl_err, exp_n, exp_mask, cnt_max, done_n, done_cyc;
    int pv_n, data_err, row_err, max_row, last_pv_cyc;
    int cs [8];
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        if (clr) seq <= 0;
        else if (bus.FIFO_rd) begin
            bus.FIFO_dout <= 10'(seq);
            seq <= seq + 1;
        end
    end
    always @(negedge clk) begin
        if (clr) begin
            rd_n = 0; rd_empty_n = 0; rl_n = 0; rl_err = 0; exp_n = 0; exp_mask = 0;
            cnt_max = 0; done_n = 0; done_cyc = 0; pv_n = 0; data_err = 0; row_err = 0;
            max_row = 0; last_pv_cyc = 0;
            for (int i = 0; i < 8; i++) cs[i] = -1;
        end else begin
            if (bus.FIFO_rd) begin
                rd_n++;
                if (bus.FIFO_empty) rd_empty_n++;
            end
            if (bus.Row_load) rl_n++;
            if (bus.Exp_en) begin
                exp_n++;
                exp_mask |= 1 << ((pv_n - 1) / 2880);
            end
            if (int'(CntSubc) > cnt_max) cnt_max = int'(CntSubc);
            if (frame_done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (bus.Pat_valid) begin
                if (pv_n % 2880 == 0 && pv_n / 2880 < 8) cs[pv_n / 2880] = int'(CntSubc);
                if (int'(bus.Pat_data) != pv_n % 1024) data_err++;
                if (int'(bus.Row_sel) != (pv_n / 18) % 160) row_err++;
                if (bus.Row_load != (pv_n % 18 == 17)) rl_err++;
                if (int'(bus.Row_sel) > max_row) max_row = int'(bus.Row_sel);
                pv_n++;
                if (pv_n == 2880) last_pv_cyc = cyc;
            end
        end
    end
    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask
    task automatic start_frame(input logic [31:0] np, input logic [31:0] ec);
        @(posedge clk); #1;
        clr = 1'b1; Num_Pat = np; Exp_cycles = ec; start = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; start = 1'b0; t0 = cyc - 1;
    endtask
    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done_n == 0 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_timeout"}, k < budget, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask
    task automatic wait_pv(input string tag, input int n, input int budget);
        int k = 0;
        while (pv_n < n && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_timeout"}, k < budget, 1);
    endtask
    initial begin
        bus.FIFO_empty = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_rd", bus.FIFO_rd, 0);
        check("rst_valid", bus.Pat_valid, 0);
        check("rst_expen", bus.Exp_en, 0);
        check("rst_cnt", CntSubc, 0);
        check("rst_stall", Stall_cnt, 0);
        check("rst_done", frame_done, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        start_frame(0, 4);
        wait_done("t1", 20000);
        check("t1_len", done_cyc - t0, 5771);
        check("t1_done_n", done_n, 1);
        check("t1_expen", exp_n, 0);
        check("t1_cnt", cnt_max, 0);
        check("t1_rd", rd_n, 5760);
        check("t1_data", data_err, 0);
        check("t1_busy", busy, 0);
        start_frame(2, 10);
        wait_done("t2", 20000);
        check("t2_len", done_cyc - t0, 11565);
        check("t2_rd", rd_n, 11520);
        check("t2_rowload", rl_n, 640);
        check("t2_rowload_pos", rl_err, 0);
        check("t2_expen", exp_n, 20);
        check("t2_expen_sf", exp_mask, 6);
        check("t2_cs0", cs[0], 0);
        check("t2_cs1", cs[1], 1);
        check("t2_cs2", cs[2], 2);
        check("t2_cs3", cs[3], 2);
        check("t2_row", row_err, 0);
        check("t2_maxrow", max_row, 159);
        check("t2_data", data_err, 0);
        start_frame(0, 4);
        wait_pv("t3", 1000, 5000);
        bus.FIFO_empty = 1'b1;
        repeat (7) @(posedge clk);
        #1 bus.FIFO_empty = 1'b0;
        wait_done("t3", 20000);
        check("t3_rd_empty", rd_empty_n, 0);
        check("t3_stall", Stall_cnt, 7);
        check("t3_load_len", last_pv_cyc - t0, 2888);
        check("t3_len", done_cyc - t0, 5778);
        check("t3_data", data_err, 0);
        check("t3_rd", rd_n, 5760);
        start_frame(1, 0);
        wait_done("t4", 20000);
        check("t4_len", done_cyc - t0, 8647);
        check("t4_expen", exp_n, 1);
        check("t4_cnt", cnt_max, 1);
        start_frame(0, 4);
        wait_pv("t5", 1000, 5000);
        #2 rst = 1'b1;
        #1;
        check("t5_busy", busy, 0);
        check("t5_rd", bus.FIFO_rd, 0);
        check("t5_valid", bus.Pat_valid, 0);
        check("t5_rowsel", bus.Row_sel, 0);
        check("t5_rowload", bus.Row_load, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        check("t5_idle", busy, 0);
        start_frame(0, 4);
        wait_done("t5", 20000);
        check("t5_len", done_cyc - t0, 5771);
        check("t5_stall", Stall_cnt, 0);
        check("t5_row", row_err, 0);
        check("t5_data", data_err, 0);
        check("t5_cs0", cs[0], 0);
        start_frame(1, 10);
        begin
            int k = 0;
            while (!bus.Exp_en && k < 10000) begin
                @(posedge clk); #1;
                k++;
            end
            check("t6_exp_timeout", k < 10000, 1);
        end
        start = 1'b1; Num_Pat = 5; Exp_cycles = 100;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("t6", 20000);
        check("t6_len", done_cyc - t0, 8674);
        check("t6_expen", exp_n, 10);
        check("t6_cnt", cnt_max, 1);
        check("t6_rd", rd_n, 8640);
        repeat (5) @(posedge clk);
        #1;
        check("t6_done_n", done_n, 1);
        check("t6_busy", busy, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/subc_sequencer.md
# subc_sequencer

Read-side controller for the pattern FIFO filled by the pattern generator. It sequences one imager frame as (Num_Pat + 2) subframes: one unexposed first subframe, Num_Pat exposed subframes, one unexposed last subframe. Each subframe has a LOAD phase, which streams C_NUM_ROWS × C_WORDS_PER_ROW pattern words from the FIFO to the imager row drivers, followed by an EXPOSE phase. The block owns the subframe counter CntSubc, which the pattern generator consumes.

## Interface
Parameters:
- C_NUM_ROWS, 160, pixel rows per subframe
- C_WORDS_PER_ROW, 18, pattern words per row
- C_WORD_W, 10, pattern word width

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  frame start pulse; honoured only in IDLE
- Num_Pat  in  32  exposed subframes per frame; latched at start
- Exp_cycles  in  32  EXPOSE phase length in clk cycles; latched at start
- FIFO_empty  in  1  pattern FIFO empty flag
- FIFO_dout  in  C_WORD_W  FIFO read data, valid 1 cycle after FIFO_rd
- FIFO_rd  out  1  FIFO read strobe
- Pat_data  out  C_WORD_W  pattern word to imager (= FIFO_dout)
- Pat_valid  out  1  Pat_data valid this cycle
- Row_sel  out  8  row index of the current Pat_valid word
- Row_load  out  1  pulse with the last word of each row
- Exp_en  out  1  exposure enable to imager
- CntSubc  out  32  index of the current exposed subframe
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle end-of-frame pulse
- Stall_cnt  out  32  LOAD cycles lost to FIFO_empty in the current frame

## Operation
- States: IDLE, LOAD, EXPOSE, DONE.
- Reset values: state = IDLE; all outputs 0; all counters 0.
- IDLE:
  - On start: latch Num_Pat and Exp_cycles; clear subframe index sf, CntSubc, Stall_cnt; go to LOAD.
- LOAD:
  - FIFO_rd = (state == LOAD) & ~FIFO_empty & (issued < C_NUM_ROWS × C_WORDS_PER_ROW).
  - Pat_valid is FIFO_rd registered.
  - Word/row counters advance on Pat_valid; word counter wraps 17→0 with row++.
  - Row_load = Pat_valid & (word == C_WORDS_PER_ROW−1).
  - Stall_cnt increments each LOAD cycle with FIFO_empty & reads outstanding; saturates at 2^32−1.
  - Exit to EXPOSE on the cycle after the last Pat_valid (row 159, word 17).
- EXPOSE:
  - Lasts max(Exp_cycles, 1) cycles.
  - Exp_en = 1 in EXPOSE iff 1 ≤ sf ≤ Num_Pat; otherwise 0.
  - On the final cycle: if sf < Num_Pat + 1, then sf++ and go to LOAD; CntSubc++ if the new sf ≤ Num_Pat.
  - Otherwise go to DONE.
- DONE: frame_done = 1 for one cycle, then IDLE.
- busy = 1 in LOAD and EXPOSE.
- Arithmetic: sf and the Num_Pat + 1 compare are 33 bits, so Num_Pat = 0xFFFFFFFF does not wrap.
- CntSubc value: 0 during the first subframe; k during exposed subframe k; Num_Pat during the last subframe.
- start outside IDLE is ignored.
- Reset mid-frame: immediate return to IDLE with all outputs 0. Any read issued in the previous cycle is dropped; FIFO flushing is the system's job.

## Timing
- start at posedge n puts the block in LOAD from cycle n+1; first FIFO_rd in cycle n+1 if the FIFO is non-empty.
- Read-to-Pat_valid latency is 1 cycle. Pat_data is combinational from FIFO_dout.
- LOAD with no stalls: 2881 cycles (2880 reads + 1 drain).
- Frame with no stalls: (Num_Pat + 2) × (2881 + max(E,1)) cycles in LOAD/EXPOSE, plus 1 DONE cycle.
- FIFO_empty is sampled combinationally; no read is issued while it is high. The FIFO must tolerate FIFO_rd in the same cycle FIFO_empty deasserts.

## Structure
- Shared package imager_pkg holds C_NUM_ROWS, C_WORDS_PER_ROW, C_WORD_W and the state encoding localparams. The pattern generator uses the same row/word constants.
- One sub-module, subc_row_counter: word/row counter with wrap, Row_load, Row_sel and a last-word flag.
- FSM, exposure timer, sf/CntSubc and Stall_cnt live in the top level.

## Test plan
- Num_Pat=0, Exp_cycles=4, FIFO always non-empty:
  - 2 subframes, Exp_en never high, CntSubc stays 0.
  - frame_done exactly 2×(2881+4)+1 cycles after start.
- Num_Pat=2, Exp_cycles=10:
  - Exp_en high for 10 cycles in subframes 1 and 2 only.
  - CntSubc sequence is 0,1,2,2.
  - 4×2880 FIFO_rd pulses; 4×160 Row_load pulses; Row_sel runs 0..159.
- FIFO_empty forced high for 7 cycles mid-LOAD:
  - No FIFO_rd during the gap; Stall_cnt=7; LOAD lasts 2888 cycles; data order preserved.
- Exp_cycles=0: EXPOSE lasts exactly 1 cycle per subframe.
- rst asserted mid-LOAD at word 1000:
  - Outputs 0 asynchronously; state IDLE.
  - A new start then begins with sf=0, Row_sel=0, Stall_cnt=0.
- start pulsed during EXPOSE, and Num_Pat changed mid-frame: no effect on the running frame or the latched values.
